conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 127 ++++++++++++
 tb/tb_conv_window_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Builds 3x3 pixel windows from a raster-order 8-bit pixel stream using two
//   line buffers and a 3x3 shift window. A window is produced for every
//   accepted pixel whose row and column are both at least 2. No edge padding
//   is applied.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   pixel offered on pix_in
//   in_sof     start-of-frame marker (qualified by an accept)
//   pix_in     8-bit unsigned pixel
//   in_ready   block can accept a pixel this cycle
//   win_out    3x3 window, pixel k = 3*row + col at bits [8k+7:8k]
//   out_valid  win_out holds a valid window
//   out_ready  downstream accepts the window
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  pix_in,
    output logic        in_ready,
    output logic [71:0] win_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] c_eff;
    logic [RW-1:0] r_eff;

    logic [7:0] lb0 [IMG_W];   // previous line
    logic [7:0] lb1 [IMG_W];   // line before that

    logic [7:0] win     [3][3];
    logic [7:0] win_nxt [3][3];
    logic [71:0] win_nxt_flat;

    logic accept;
    logic emit;
    logic last_pix;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign c_eff = in_sof ? '0 : col;
    assign r_eff = in_sof ? '0 : row;

    assign emit     = accept && (r_eff >= RW'(2)) && (c_eff >= CW'(2));
    assign last_pix = accept && (r_eff == RW'(IMG_H - 1)) && (c_eff == CW'(IMG_W - 1));

    // Window after the shift this accept would cause; also feeds win_out so
    // the output carries the window including the pixel just accepted.
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb1[c_eff];
        win_nxt[1][2] = lb0[c_eff];
        win_nxt[2][2] = pix_in;
        win_nxt_flat  = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned q = 0; q < 3; q++) begin
                win_nxt_flat[8*(3*r+q) +: 8] = win_nxt[r][q];
            end
        end
    end

    // Line buffers carry no reset: rows 0 and 1 of every frame rewrite them
    // before any window depends on their contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[c_eff] <= lb0[c_eff];
            lb0[c_eff] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            win_out    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned q = 0; q < 3; q++) begin
                    win[r][q] <= '0;
                end
            end
        end else begin
            frame_done <= last_pix;
            if (accept) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned q = 0; q < 3; q++) begin
                        win[r][q] <= win_nxt[r][q];
                    end
                end
                if (c_eff == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (r_eff == RW'(IMG_H - 1)) ? '0 : r_eff + RW'(1);
                end else begin
                    col <= c_eff + CW'(1);
                    row <= r_eff;
                end
            end
            if (emit) begin
                out_valid <= 1'b1;
                win_out   <= win_nxt_flat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Self-checking bench for conv_window_gen on a 4x4 image: a table of
//   per-cycle vectors for the basic stream, then hand-written sequences for
//   back-pressure, mid-frame sof, mid-frame reset, and a randomized run
//   checked against a frame-array reference.
module tb_conv_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        in_ready;
    logic [71:0] win_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_done;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .pix_in(pix_in), .in_ready(in_ready), .win_out(win_out),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [71:0] got[$];
    int fd_cnt;
    int acc_at_first;

    typedef struct {
        logic       v;
        logic       sof;
        logic [7:0] pix;
        logic       ordy;
        logic       e_ov;
        int         e_tl;
        logic       e_fd;
        logic       e_rdy;
    } vec_t;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window of a stream whose pixel values equal their raster index,
    // identified by the index of its top-left pixel.
    function automatic logic [71:0] seq_win(input int tl);
        logic [71:0] w = '0;
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++)
                w[8*(3*r+q) +: 8] = 8'(tl + W*r + q);
        return w;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst out_valid", 72'(out_valid), 72'(0));
        chk("rst frame_done", 72'(frame_done), 72'(0));
        chk("rst win_out", win_out, 72'(0));
        chk("rst in_ready", 72'(in_ready), 72'(1));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Streams pixel values 0..npix-1, optional sof on the first one. When
    // stall_len > 0, out_ready is held low for stall_len cycles as soon as the
    // first window appears; during that time the block must stall and hold.
    task automatic run_frame(input int npix, input bit sof0, input int stall_len);
        int p = 0;
        int budget = 0;
        int drain = 0;
        int stall_left = -1;
        bit acc, hs;
        while ((p < npix || drain < 3) && budget < 400) begin
            @(posedge clk);
            #1;
            if (frame_done) fd_cnt++;
            if (out_valid && stall_left == -1 && stall_len > 0 && got.size() == 0)
                stall_left = stall_len;
            out_ready = !(stall_left > 0);
            in_valid  = (p < npix);
            in_sof    = sof0 && (p == 0);
            pix_in    = 8'(p);
            #1;
            if (stall_left > 0) begin
                chk("stall in_ready", 72'(in_ready), 72'(0));
                chk("stall win_out", win_out, seq_win(0));
                stall_left--;
            end
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (got.size() == 0) acc_at_first = p;
                got.push_back(win_out);
            end
            if (acc) p++;
            if (p >= npix && !acc) drain++;
            budget++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (budget >= 400) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_frame timeout: accepted %0d required %0d", p, npix);
        end
    endtask

    task automatic check_std_windows(input string name);
        int tl[4] = '{0, 1, 4, 5};
        chk({name, " count"}, 72'(got.size()), 72'(4));
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("%s win%0d", name, i + 1), got[i], seq_win(tl[i]));
    endtask

    vec_t vec[18];

    logic [7:0]  px[3*W*H];
    logic [71:0] expq[$];

    initial begin
        // Basic stream, pixels 0..15 every cycle, out_ready high.
        //         v  sof pix   ordy ev  tl  fd  rdy
        vec[0]  = '{1, 1, 8'd0,  1, 0, 0, 0, 1};
        vec[1]  = '{1, 0, 8'd1,  1, 0, 0, 0, 1};
        vec[2]  = '{1, 0, 8'd2,  1, 0, 0, 0, 1};
        vec[3]  = '{1, 0, 8'd3,  1, 0, 0, 0, 1};
        vec[4]  = '{1, 0, 8'd4,  1, 0, 0, 0, 1};
        vec[5]  = '{1, 0, 8'd5,  1, 0, 0, 0, 1};
        vec[6]  = '{1, 0, 8'd6,  1, 0, 0, 0, 1};
        vec[7]  = '{1, 0, 8'd7,  1, 0, 0, 0, 1};
        vec[8]  = '{1, 0, 8'd8,  1, 0, 0, 0, 1};
        vec[9]  = '{1, 0, 8'd9,  1, 0, 0, 0, 1};
        vec[10] = '{1, 0, 8'd10, 1, 0, 0, 0, 1};
        vec[11] = '{1, 0, 8'd11, 1, 1, 0, 0, 1};
        vec[12] = '{1, 0, 8'd12, 1, 1, 1, 0, 1};
        vec[13] = '{1, 0, 8'd13, 1, 0, 0, 0, 1};
        vec[14] = '{1, 0, 8'd14, 1, 0, 0, 0, 1};
        vec[15] = '{1, 0, 8'd15, 1, 1, 4, 0, 1};
        vec[16] = '{0, 0, 8'd0,  1, 1, 5, 1, 1};
        vec[17] = '{0, 0, 8'd0,  1, 0, 0, 0, 1};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            in_valid  = vec[i].v;
            in_sof    = vec[i].sof;
            pix_in    = vec[i].pix;
            out_ready = vec[i].ordy;
            #1;
            chk($sformatf("vec%0d out_valid", i), 72'(out_valid), 72'(vec[i].e_ov));
            chk($sformatf("vec%0d frame_done", i), 72'(frame_done), 72'(vec[i].e_fd));
            chk($sformatf("vec%0d in_ready", i), 72'(in_ready), 72'(vec[i].e_rdy));
            if (vec[i].e_ov)
                chk($sformatf("vec%0d win_out", i), win_out, seq_win(vec[i].e_tl));
        end
        in_valid = 1'b0;

        // Back-pressure: 5 stalled cycles after window 1.
        do_reset();
        got.delete(); fd_cnt = 0;
        run_frame(16, 1'b0, 5);
        check_std_windows("stall");
        chk("stall frame_done", 72'(fd_cnt), 72'(1));

        // sof at the 7th pixel aborts the partial frame.
        do_reset();
        got.delete(); fd_cnt = 0; acc_at_first = -1;
        run_frame(6, 1'b1, 0);
        chk("abort windows", 72'(got.size()), 72'(0));
        run_frame(16, 1'b1, 0);
        check_std_windows("sof");
        chk("sof frame_done", 72'(fd_cnt), 72'(1));
        chk("sof first window after", 72'(acc_at_first), 72'(11));

        // Reset mid-frame after pixel 9; next frame starts at (0,0) without sof.
        do_reset();
        got.delete(); fd_cnt = 0;
        run_frame(10, 1'b0, 0);
        do_reset();
        chk("midrst windows before", 72'(got.size()), 72'(0));
        got.delete(); fd_cnt = 0;
        run_frame(16, 1'b0, 0);
        check_std_windows("midrst");
        chk("midrst frame_done", 72'(fd_cnt), 72'(1));

        // Random pixels with random gaps, three frames, frame-array reference.
        do_reset();
        for (int i = 0; i < 3*W*H; i++) px[i] = 8'($urandom_range(0, 255));
        begin
            int idx = 0;
            int cyc = 0;
            int tail = 0;
            int nwin = 0;
            int f, pos, r, c;
            bit acc, hs;
            logic [71:0] e;
            fd_cnt = 0;
            while ((idx < 3*W*H || expq.size() != 0 || tail < 3) && cyc < 3000) begin
                @(posedge clk);
                #1;
                if (frame_done) fd_cnt++;
                in_valid  = (idx < 3*W*H) && ($urandom_range(0, 9) < 7);
                in_sof    = 1'b0;
                pix_in    = (idx < 3*W*H) ? px[idx] : 8'd0;
                out_ready = ($urandom_range(0, 9) < 7);
                #1;
                acc = in_valid && in_ready;
                hs  = out_valid && out_ready;
                if (hs) begin
                    nwin++;
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rand extra window: got %h required none", win_out);
                    end else begin
                        e = expq.pop_front();
                        chk($sformatf("rand win%0d", nwin), win_out, e);
                    end
                end
                if (acc) begin
                    f = idx / (W*H);
                    pos = idx % (W*H);
                    r = pos / W;
                    c = pos % W;
                    if (r >= 2 && c >= 2) begin
                        e = '0;
                        for (int rr = 0; rr < 3; rr++)
                            for (int q = 0; q < 3; q++)
                                e[8*(3*rr+q) +: 8] = px[f*W*H + (r-2+rr)*W + (c-2+q)];
                        expq.push_back(e);
                    end
                    idx++;
                end
                if (idx == 3*W*H && expq.size() == 0) tail++;
                cyc++;
            end
            in_valid = 1'b0;
            chk("rand windows", 72'(nwin), 72'(3*(W-2)*(H-2)));
            chk("rand frame_done", 72'(fd_cnt), 72'(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
